// File: rtl/mux_n21_pipe.sv
// N-to-1 word selector feeding a 2-entry skid buffer with registered valid/ready.
// Optional macro MUX_SEL_ERR_EN: out-of-range selects store zero and set a sticky w_sel_err.
module mux_n21_pipe #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic                        w_clk,
   input  logic                        w_rst_n,
   input  logic [NUM_INPUTS*WIDTH-1:0] w_inputs_x,
   input  logic [SEL_WIDTH-1:0]        w_ctrl,
   input  logic                        w_in_valid,
   output logic                        w_in_ready,
   output logic [WIDTH-1:0]            w_out_x,
   output logic                        w_out_valid,
   input  logic                        w_out_ready,
   output logic                        w_sel_err
);

   localparam bit FULL_DECODE = ((1 << SEL_WIDTH) == NUM_INPUTS);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] w_main_nxt;
   logic [WIDTH-1:0] w_skid_nxt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_sel_in_range;
   logic [WIDTH-1:0] w_sel_dflt;
   logic [WIDTH-1:0] w_sel_data;
   logic [WIDTH-1:0] w_chan [NUM_INPUTS];

   // Unpack channels so an unknown select reads back as a fully unknown word.
   for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_chan
      assign w_chan[k] = w_inputs_x[k*WIDTH +: WIDTH];
   end

   if (FULL_DECODE) begin : g_full_dec
      assign w_sel_in_range = 1'b1;
   end else begin : g_part_dec
      assign w_sel_in_range = (32'(w_ctrl) < NUM_INPUTS);
   end

`ifdef MUX_SEL_ERR_EN
   assign w_sel_dflt = '0;
`else
   assign w_sel_dflt = w_chan[0];
`endif

   assign w_sel_data = w_sel_in_range ? w_chan[w_ctrl] : w_sel_dflt;

   assign w_in_fire  = w_in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & w_out_ready;

   // State and datapath registers
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= S_EMPTY;
         r_main      <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_main      <= w_main_nxt;
         r_skid      <= w_skid_nxt;
         r_in_ready  <= (w_state_nxt != S_FULL);
         r_out_valid <= (w_state_nxt != S_EMPTY);
      end
   end

   // Next state; the select is evaluated only on an accepted word
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      unique case (r_state)
         S_EMPTY: begin
            if (w_in_fire) begin
               w_state_nxt = S_ONE;
               w_main_nxt  = w_sel_data;
            end
         end
         S_ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_main_nxt = w_sel_data;
            end else if (w_in_fire) begin
               w_state_nxt = S_FULL;
               w_skid_nxt  = w_sel_data;
            end else if (w_out_fire) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            if (w_out_fire) begin
               w_state_nxt = S_ONE;
               w_main_nxt  = r_skid;
            end
         end
         default: begin
            w_state_nxt = S_EMPTY;
         end
      endcase
   end

`ifdef MUX_SEL_ERR_EN
   logic r_sel_err;

   // Sticky until reset; the flagged word still flows through in order
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_sel_err <= 1'b0;
      end else if (w_in_fire && !w_sel_in_range) begin
         r_sel_err <= 1'b1;
      end
   end

   assign w_sel_err = r_sel_err;
`else
   assign w_sel_err = 1'b0;
`endif

   assign w_in_ready  = r_in_ready;
   assign w_out_valid = r_out_valid;
   assign w_out_x     = r_main;

endmodule
